dmem_line_responder: RTL and testbench

- Responder end of the MEM-stage data-memory port. It accepts word-granular read/write requests (address, wdata, byte enables) and returns rdata plus a one-cycle resp.
- Holds one 256-bit line buffer, write-back and write-allocate, in front of a line-granular physical memory port.
- Misses evict the dirty line, then fetch the new line. Hits respond with no pmem traffic.
- Sits between the pipeline data port and the arbiter/pmem.

---
 rtl/dmem_line_responder_pkg.sv | 14 +
 rtl/dmem_line_responder_if.sv | 37 +++
 rtl/dmem_line_merge.sv | 25 ++
 rtl/dmem_line_responder.sv | 141 ++++++++++++++
 tb/tb_dmem_line_responder.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_line_responder_pkg.sv
// Shared types and geometry for the MEM-stage data-memory line responder.
// Lives alongside rv32i_types; import with dmem_line_responder_pkg::*.
package dmem_line_responder_pkg;

  localparam int unsigned OFFSET_BITS   = 5;  // byte offset within a 256-bit line
  localparam int unsigned WORD_SEL_BITS = 3;  // word index within a line, address[4:2]

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FETCH
  } dmem_state_t;

endpackage

// File: rtl/dmem_line_responder_if.sv
// Pipeline data port plus line-granular pmem port of the data-memory responder.
// slave is the responder's view; master is the view of the pipeline/pmem side.
interface dmem_line_responder_if #(
  parameter int unsigned width      = 32,
  parameter int unsigned line_width = 256
);

  logic                  mem_read_i;
  logic                  mem_write_i;
  logic [width-1:0]      mem_address_i;
  logic [width-1:0]      mem_wdata_i;
  logic [width/8-1:0]    mem_byte_en_i;
  logic [width-1:0]      mem_rdata_o;
  logic                  mem_resp_o;

  logic                  pmem_read_o;
  logic                  pmem_write_o;
  logic [width-1:0]      pmem_address_o;
  logic [line_width-1:0] pmem_wdata_o;
  logic [line_width-1:0] pmem_rdata_i;
  logic                  pmem_resp_i;

  modport slave (
    input  mem_read_i, mem_write_i, mem_address_i, mem_wdata_i, mem_byte_en_i,
    output mem_rdata_o, mem_resp_o,
    output pmem_read_o, pmem_write_o, pmem_address_o, pmem_wdata_o,
    input  pmem_rdata_i, pmem_resp_i
  );

  modport master (
    output mem_read_i, mem_write_i, mem_address_i, mem_wdata_i, mem_byte_en_i,
    input  mem_rdata_o, mem_resp_o,
    input  pmem_read_o, pmem_write_o, pmem_address_o, pmem_wdata_o,
    output pmem_rdata_i, pmem_resp_i
  );

endinterface

// File: rtl/dmem_line_merge.sv
// Byte-lane merge of one store word into a cache line (purely combinational).
module dmem_line_merge
  import dmem_line_responder_pkg::*;
#(
  parameter int unsigned width      = 32,
  parameter int unsigned line_width = 256
) (
  input  logic [line_width-1:0]    line,
  input  logic [WORD_SEL_BITS-1:0] word_sel,
  input  logic [width-1:0]         wdata,
  input  logic [width/8-1:0]       byte_en,
  output logic [line_width-1:0]    merged_line
);

  // Overwrite only the enabled byte lanes of the selected word
  always_comb begin
    merged_line = line;
    for (int unsigned b = 0; b < width / 8; b++) begin
      if (byte_en[b]) begin
        merged_line[word_sel * width + b * 8 +: 8] = wdata[b * 8 +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_line_responder.sv
// Single-line write-back, write-allocate buffer between the MEM-stage data
// port and the line-granular physical memory port.
module dmem_line_responder
  import dmem_line_responder_pkg::*;
#(
  parameter int unsigned width      = 32,
  parameter int unsigned line_width = 256
) (
  input logic                  clk,
  input logic                  rst,
  dmem_line_responder_if.slave bus
);

  localparam int unsigned tag_bits = width - OFFSET_BITS;

  dmem_state_t           state;
  dmem_state_t           next_state;
  logic                  valid;
  logic                  dirty;
  logic [tag_bits-1:0]   tag;
  logic [line_width-1:0] line;
  logic [line_width-1:0] merged_line;

  logic                     req;
  logic                     hit;
  logic [tag_bits-1:0]      req_tag;
  logic [WORD_SEL_BITS-1:0] word_sel;

  logic             resp;
  logic             pmem_read;
  logic             pmem_write;
  logic [width-1:0] pmem_address;

  assign req      = bus.mem_read_i | bus.mem_write_i;
  assign req_tag  = bus.mem_address_i[width-1:OFFSET_BITS];
  assign word_sel = bus.mem_address_i[OFFSET_BITS-1:2];
  assign hit      = valid && (tag == req_tag);

  dmem_line_merge #(
    .width      (width),
    .line_width (line_width)
  ) u_merge (
    .line        (line),
    .word_sel    (word_sel),
    .wdata       (bus.mem_wdata_i),
    .byte_en     (bus.mem_byte_en_i),
    .merged_line (merged_line)
  );

  assign bus.mem_rdata_o    = line[word_sel * width +: width];
  assign bus.mem_resp_o     = resp;
  assign bus.pmem_read_o    = pmem_read;
  assign bus.pmem_write_o   = pmem_write;
  assign bus.pmem_address_o = pmem_address;
  assign bus.pmem_wdata_o   = line;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state, hit response and pmem strobes
  always_comb begin
    next_state   = state;
    resp         = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    case (state)
      IDLE: begin
        if (req) begin
          if (hit) begin
            resp = 1'b1;
          end else if (valid && dirty) begin
            next_state = WRITEBACK;
          end else begin
            next_state = FETCH;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag, {OFFSET_BITS{1'b0}}};
        if (bus.pmem_resp_i) begin
          next_state = FETCH;
        end
      end
      FETCH: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag, {OFFSET_BITS{1'b0}}};
        if (bus.pmem_resp_i) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Line buffer, tag and status bits: store merge on hit, clean on writeback, install on fetch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      dirty <= 1'b0;
      tag   <= '0;
      line  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && hit && bus.mem_write_i) begin
            line <= merged_line;
            if (|bus.mem_byte_en_i) begin
              dirty <= 1'b1;
            end
          end
        end
        WRITEBACK: begin
          if (bus.pmem_resp_i) begin
            dirty <= 1'b0;
          end
        end
        FETCH: begin
          if (bus.pmem_resp_i) begin
            line  <= bus.pmem_rdata_i;
            tag   <= req_tag;
            valid <= 1'b1;
            dirty <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_line_responder.sv
// Bench for dmem_line_responder: directed scenarios plus a randomized run,
// checked against a word-level memory image and a one-line residency model.
module tb_dmem_line_responder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dmem_line_responder_if #(.width(32), .line_width(256)) bus ();

  dmem_line_responder #(
    .width      (32),
    .line_width (256)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Backing store and the value the CPU should observe, both per word address
  logic [31:0] pmem_words [logic [29:0]];
  logic [31:0] gold_words [logic [29:0]];

  function automatic logic [31:0] init_word(input logic [29:0] w);
    return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] pmem_rd(input logic [29:0] w);
    return pmem_words.exists(w) ? pmem_words[w] : init_word(w);
  endfunction

  function automatic logic [31:0] gold_rd(input logic [29:0] w);
    return gold_words.exists(w) ? gold_words[w] : init_word(w);
  endfunction

  // pmem responder: fixed latency per transfer, one-cycle resp, logs what it saw
  int unsigned  lat = 5;
  int unsigned  busy = 0;
  int unsigned  n_rd = 0;
  int unsigned  n_wr = 0;
  int unsigned  strobe_both = 0;
  logic [31:0]  last_rd_addr;
  logic [31:0]  last_wr_addr;
  logic [255:0] last_wr_data;
  logic [255:0] fetch_line;
  logic [31:0]  p_addr;

  initial begin
    bus.pmem_resp_i  = 1'b0;
    bus.pmem_rdata_i = '0;
    forever begin
      @(posedge clk); #1;
      bus.pmem_resp_i = 1'b0;
      if (bus.pmem_read_o && bus.pmem_write_o) strobe_both++;
      if (rst && (bus.pmem_read_o || bus.pmem_write_o)) begin
        busy++;
        if (busy >= lat) begin
          busy   = 0;
          p_addr = bus.pmem_address_o;
          if (bus.pmem_write_o) begin
            n_wr++;
            last_wr_addr = p_addr;
            last_wr_data = bus.pmem_wdata_o;
            for (int i = 0; i < 8; i++)
              pmem_words[{p_addr[31:5], 3'(i)}] = last_wr_data[i*32 +: 32];
          end else begin
            n_rd++;
            last_rd_addr = p_addr;
            for (int i = 0; i < 8; i++)
              fetch_line[i*32 +: 32] = pmem_rd({p_addr[31:5], 3'(i)});
            bus.pmem_rdata_i = fetch_line;
          end
          bus.pmem_resp_i = 1'b1;
        end
      end else begin
        busy = 0;
      end
    end
  end

  // Residency model: which line is held and whether it differs from pmem
  bit          m_valid = 1'b0;
  bit          m_dirty = 1'b0;
  logic [26:0] m_tag   = '0;
  logic [31:0] last_rdata;

  task automatic req_check(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
    bit          hit;
    bit          exp_wb;
    bit          done;
    int unsigned exp_wait;
    int unsigned waits;
    logic [26:0] old_tag;
    logic [29:0] w;
    logic [31:0] word;
    w        = addr[31:2];
    hit      = m_valid && (m_tag == addr[31:5]);
    exp_wb   = !hit && m_valid && m_dirty;
    exp_wait = hit ? 0 : 1 + lat * (exp_wb ? 2 : 1);
    old_tag  = m_tag;

    @(posedge clk); #1;
    n_rd = 0;
    n_wr = 0;
    bus.mem_read_i    = rd;
    bus.mem_write_i   = wr;
    bus.mem_address_i = addr;
    bus.mem_wdata_i   = wdata;
    bus.mem_byte_en_i = be;

    waits = 0;
    done  = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (bus.mem_resp_o) done = 1'b1;
      else begin
        waits++;
        if (waits > 400) done = 1'b1;
      end
    end
    last_rdata = bus.mem_rdata_o;

    check_eq("resp_wait", waits, exp_wait);
    check_eq("pmem_rd_cnt", n_rd, hit ? 0 : 1);
    check_eq("pmem_wr_cnt", n_wr, exp_wb ? 1 : 0);
    if (!hit) check_eq("fetch_addr", last_rd_addr, {addr[31:5], 5'b0});
    if (exp_wb) check_eq("wb_addr", last_wr_addr, {old_tag, 5'b0});

    if (wr) begin
      word = gold_rd(w);
      for (int b = 0; b < 4; b++)
        if (be[b]) word[b*8 +: 8] = wdata[b*8 +: 8];
      gold_words[w] = word;
    end else begin
      check_eq("rdata", last_rdata, gold_rd(w));
    end

    if (!hit) begin
      m_valid = 1'b1;
      m_tag   = addr[31:5];
      m_dirty = 1'b0;
    end
    if (wr && be != 4'b0) m_dirty = 1'b1;
  endtask

  initial begin
    rst               = 1'b0;
    bus.mem_read_i    = 1'b0;
    bus.mem_write_i   = 1'b0;
    bus.mem_address_i = '0;
    bus.mem_wdata_i   = '0;
    bus.mem_byte_en_i = '0;

    pmem_words[30'h41] = 32'hDEAD_BEEF;
    gold_words[30'h41] = 32'hDEAD_BEEF;
    pmem_words[30'h42] = 32'h0BAD_F00D;
    gold_words[30'h42] = 32'h0BAD_F00D;

    repeat (2) @(negedge clk);
    check_eq("rst_resp", bus.mem_resp_o, 0);
    check_eq("rst_rdata", bus.mem_rdata_o, 0);
    check_eq("rst_pmem_read", bus.pmem_read_o, 0);
    check_eq("rst_pmem_write", bus.pmem_write_o, 0);
    check_eq("rst_pmem_addr", bus.pmem_address_o, 0);
    check_eq("rst_pmem_wdata_any", 64'(|bus.pmem_wdata_o), 0);
    rst = 1'b1;

    lat = 5;
    req_check(1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'h0);
    check_eq("cold_read_data", last_rdata, 32'hDEAD_BEEF);
    req_check(1'b1, 1'b0, 32'h0000_0108, 32'h0, 4'h0);
    check_eq("hit_read_data", last_rdata, 32'h0BAD_F00D);
    req_check(1'b0, 1'b1, 32'h0000_0104, 32'h1234_5678, 4'b1100);
    req_check(1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'h0);
    check_eq("partial_write_data", last_rdata, 32'h1234_BEEF);
    req_check(1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
    check_eq("evict_word1", last_wr_data[63:32], 32'h1234_BEEF);
    req_check(1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'h0);
    req_check(1'b0, 1'b1, 32'h0000_0304, 32'hFFFF_FFFF, 4'b0000);
    req_check(1'b1, 1'b0, 32'h0000_0304, 32'h0, 4'h0);
    req_check(1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'h0);
    check_eq("refetch_after_evict", last_rdata, 32'h1234_BEEF);
    req_check(1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'h0);

    // Asynchronous reset while a fetch is outstanding
    @(posedge clk); #1;
    bus.mem_read_i    = 1'b1;
    bus.mem_write_i   = 1'b0;
    bus.mem_address_i = 32'h0000_0200;
    repeat (3) @(negedge clk);
    check_eq("mid_fetch_strobe", bus.pmem_read_o, 1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check_eq("reset_drops_read", bus.pmem_read_o, 0);
    check_eq("reset_drops_write", bus.pmem_write_o, 0);
    check_eq("reset_clears_addr", bus.pmem_address_o, 0);
    bus.mem_read_i = 1'b0;
    m_valid = 1'b0;
    m_dirty = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    req_check(1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0);

    req_check(1'b1, 1'b1, 32'h0000_0200, 32'h0000_00AA, 4'b0001);
    req_check(1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
    check_eq("rd_wr_as_store", last_rdata[7:0], 8'hAA);

    lat = 20;
    req_check(1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'h0);

    for (int n = 0; n < 200; n++) begin
      logic [31:0] addr;
      int unsigned op;
      addr = 32'h0000_1000 + 32'($urandom_range(0, 3)) * 32
           + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
      op   = $urandom_range(0, 3);
      lat  = $urandom_range(1, 4);
      req_check(op == 0 || op == 1 || op == 3, op >= 2, addr, $urandom, 4'($urandom));
    end

    @(posedge clk); #1;
    bus.mem_read_i  = 1'b0;
    bus.mem_write_i = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("strobe_overlap", strobe_both, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
